// File: rtl/ahb_package.sv
// Shared AHB types: transfer types, slave responses,
// and the default-slave state encoding.
package AHB_package;

   typedef enum logic [1:0] {
      TRANS_IDLE   = 2'b00,
      TRANS_BUSY   = 2'b01,
      TRANS_NONSEQ = 2'b10,
      TRANS_SEQ    = 2'b11
   } htrans_type;

   typedef enum logic [1:0] {
      OKAY  = 2'b00,
      ERROR = 2'b01,
      RETRY = 2'b10,
      SPLIT = 2'b11
   } hresp_type;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ERR1 = 2'b01,
      ERR2 = 2'b10
   } dslv_state_e;

   function automatic logic is_active(htrans_type t);
      return (t == TRANS_NONSEQ) || (t == TRANS_SEQ);
   endfunction

endpackage

// File: rtl/ahb_default_slave_log.sv
// Debug log of the most recent faulting access plus a
// saturating fault counter.
module ahb_default_slave_log #(
   parameter int AHB_ADDR_WIDTH = 32,
   parameter int ERR_CNT_WIDTH  = 8
) (
   input  logic                      hclk,
   input  logic                      hreset,
   input  logic                      log_en,
   input  logic                      err_clr,
   input  logic [AHB_ADDR_WIDTH-1:0] haddr,
   input  logic                      hwrite,
   output logic                      err_valid,
   output logic [AHB_ADDR_WIDTH-1:0] err_addr,
   output logic                      err_write,
   output logic [ERR_CNT_WIDTH-1:0]  err_count
);

   logic saturated;

   assign saturated = &err_count;

   // A fault in the same cycle as a clear restarts the count at one.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         err_valid <= 1'b0;
         err_addr  <= '0;
         err_write <= 1'b0;
         err_count <= '0;
      end else if (log_en) begin
         err_valid <= 1'b1;
         err_addr  <= haddr;
         err_write <= hwrite;
         if (err_clr)
            err_count <= ERR_CNT_WIDTH'(1);
         else if (!saturated)
            err_count <= err_count + 1'b1;
      end else if (err_clr) begin
         err_valid <= 1'b0;
         err_count <= '0;
      end
   end

endmodule

// File: rtl/ahb_default_slave.sv
// AHB default slave: two-cycle ERROR for active transfers
// to unmapped space, zero-wait OKAY for IDLE/BUSY.
module ahb_default_slave
   import AHB_package::*;
#(
   parameter int AHB_ADDR_WIDTH = 32,
   parameter int AHB_DATA_WIDTH = 32,
   parameter int ERR_CNT_WIDTH  = 8
) (
   input  logic                      hclk,
   input  logic                      hreset,
   input  logic                      hsel,
   input  logic [AHB_ADDR_WIDTH-1:0] haddr,
   input  htrans_type                htrans,
   input  logic                      hwrite,
   input  logic                      hready,
   output logic                      hreadyout,
   output hresp_type                 hresp,
   output logic [AHB_DATA_WIDTH-1:0] hrdata,
   input  logic                      err_clr,
   output logic                      err_valid,
   output logic [AHB_ADDR_WIDTH-1:0] err_addr,
   output logic                      err_write,
   output logic [ERR_CNT_WIDTH-1:0]  err_count
);

   dslv_state_e state;
   dslv_state_e state_nxt;
   logic        accept;
   logic        log_en;

   assign accept = hsel && hready && is_active(htrans);

   always_ff @(posedge hclk) begin
      if (hreset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // ERR1 owns the data phase, so nothing is sampled there.
   always_comb begin
      state_nxt = state;
      log_en    = 1'b0;
      hreadyout = 1'b1;
      hresp     = OKAY;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = ERR1;
               log_en    = 1'b1;
            end
         end
         ERR1: begin
            hreadyout = 1'b0;
            hresp     = ERROR;
            state_nxt = ERR2;
         end
         ERR2: begin
            hresp = ERROR;
            if (accept) begin
               state_nxt = ERR1;
               log_en    = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign hrdata = '0;

   ahb_default_slave_log #(
      .AHB_ADDR_WIDTH(AHB_ADDR_WIDTH),
      .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
   ) u_log (
      .hclk     (hclk),
      .hreset   (hreset),
      .log_en   (log_en),
      .err_clr  (err_clr),
      .haddr    (haddr),
      .hwrite   (hwrite),
      .err_valid(err_valid),
      .err_addr (err_addr),
      .err_write(err_write),
      .err_count(err_count)
   );

endmodule

// File: tb/tb_ahb_default_slave.sv
// Directed vector bench for ahb_default_slave, including a
// narrow-counter instance for saturation.
module tb_ahb_default_slave;
   import AHB_package::*;

   logic        hclk = 1'b0;
   logic        hreset;
   logic        hsel;
   logic [31:0] haddr;
   htrans_type  htrans;
   logic        hwrite;
   logic        hready;
   logic        err_clr;

   logic        hreadyout, hreadyout2;
   hresp_type   hresp, hresp2;
   logic [31:0] hrdata, hrdata2;
   logic        err_valid, err_valid2;
   logic [31:0] err_addr, err_addr2;
   logic        err_write, err_write2;
   logic [7:0]  err_count;
   logic [1:0]  err_count2;

   int checks = 0;
   int errors = 0;

   always #5 hclk = ~hclk;

   ahb_default_slave dut (
      .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr),
      .htrans(htrans), .hwrite(hwrite), .hready(hready),
      .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
      .err_clr(err_clr), .err_valid(err_valid), .err_addr(err_addr),
      .err_write(err_write), .err_count(err_count)
   );

   ahb_default_slave #(.ERR_CNT_WIDTH(2)) dut2 (
      .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr),
      .htrans(htrans), .hwrite(hwrite), .hready(hready),
      .hreadyout(hreadyout2), .hresp(hresp2), .hrdata(hrdata2),
      .err_clr(err_clr), .err_valid(err_valid2), .err_addr(err_addr2),
      .err_write(err_write2), .err_count(err_count2)
   );

   typedef struct {
      logic        rst;
      logic        sel;
      logic        rdy;
      htrans_type  trans;
      logic [31:0] addr;
      logic        wr;
      logic        clr;
      logic        e_ready;
      hresp_type   e_resp;
      logic        e_valid;
      logic [7:0]  e_count;
      logic [31:0] e_addr;
      logic        e_write;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(
      logic rst, logic sel, logic rdy, htrans_type trans,
      logic [31:0] addr, logic wr, logic clr,
      logic e_ready, hresp_type e_resp, logic e_valid,
      logic [7:0] e_count, logic [31:0] e_addr, logic e_write);
      vec_t v;
      v.rst = rst; v.sel = sel; v.rdy = rdy; v.trans = trans;
      v.addr = addr; v.wr = wr; v.clr = clr;
      v.e_ready = e_ready; v.e_resp = e_resp; v.e_valid = e_valid;
      v.e_count = e_count; v.e_addr = e_addr; v.e_write = e_write;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(logic rst, logic sel, logic rdy, htrans_type t,
                        logic [31:0] a, logic wr, logic clr);
      hreset = rst; hsel = sel; hready = rdy; htrans = t;
      haddr = a; hwrite = wr; err_clr = clr;
   endtask

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   task automatic idle_in();
      drive(1'b0, 1'b0, 1'b1, TRANS_IDLE, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      // Tests 1, 2, 3, 6 and clear-without-accept.
      vecs[0]  = mk(1,0,1,TRANS_IDLE,  32'h0,   0,0, 1,OKAY, 0,0,32'h0,   0);
      vecs[1]  = mk(0,1,1,TRANS_NONSEQ,32'h200, 1,0, 0,ERROR,1,1,32'h200, 1);
      vecs[2]  = mk(0,0,0,TRANS_IDLE,  32'h0,   0,0, 1,ERROR,1,1,32'h200, 1);
      vecs[3]  = mk(0,1,1,TRANS_IDLE,  32'h300, 0,0, 1,OKAY, 1,1,32'h200, 1);
      vecs[4]  = mk(1,0,1,TRANS_IDLE,  32'h0,   0,0, 1,OKAY, 0,0,32'h0,   0);
      vecs[5]  = mk(0,1,1,TRANS_IDLE,  32'h440, 0,0, 1,OKAY, 0,0,32'h0,   0);
      vecs[6]  = mk(0,1,1,TRANS_BUSY,  32'h444, 1,0, 1,OKAY, 0,0,32'h0,   0);
      vecs[7]  = mk(0,1,1,TRANS_BUSY,  32'h448, 0,0, 1,OKAY, 0,0,32'h0,   0);
      vecs[8]  = mk(0,1,1,TRANS_NONSEQ,32'h1000,0,0, 0,ERROR,1,1,32'h1000,0);
      vecs[9]  = mk(0,1,0,TRANS_IDLE,  32'h0,   0,0, 1,ERROR,1,1,32'h1000,0);
      vecs[10] = mk(0,1,1,TRANS_SEQ,   32'h1004,1,0, 0,ERROR,1,2,32'h1004,1);
      vecs[11] = mk(0,1,0,TRANS_IDLE,  32'h0,   0,0, 1,ERROR,1,2,32'h1004,1);
      vecs[12] = mk(0,0,1,TRANS_IDLE,  32'h0,   0,0, 1,OKAY, 1,2,32'h1004,1);
      vecs[13] = mk(0,1,0,TRANS_NONSEQ,32'h2000,0,0, 1,OKAY, 1,2,32'h1004,1);
      vecs[14] = mk(0,1,0,TRANS_SEQ,   32'h2004,0,0, 1,OKAY, 1,2,32'h1004,1);
      vecs[15] = mk(0,0,1,TRANS_IDLE,  32'h0,   0,1, 1,OKAY, 0,0,32'h1004,1);

      idle_in();
      hreset = 1'b1;
      step();

      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].rst, vecs[i].sel, vecs[i].rdy, vecs[i].trans,
               vecs[i].addr, vecs[i].wr, vecs[i].clr);
         step();
         chk($sformatf("v%0d hreadyout", i), 32'(hreadyout), 32'(vecs[i].e_ready));
         chk($sformatf("v%0d hresp", i), 32'(hresp), 32'(vecs[i].e_resp));
         chk($sformatf("v%0d err_valid", i), 32'(err_valid), 32'(vecs[i].e_valid));
         chk($sformatf("v%0d err_count", i), 32'(err_count), 32'(vecs[i].e_count));
         chk($sformatf("v%0d err_addr", i), err_addr, vecs[i].e_addr);
         chk($sformatf("v%0d err_write", i), 32'(err_write), 32'(vecs[i].e_write));
         chk($sformatf("v%0d hrdata", i), hrdata, 32'h0);
         chk($sformatf("v%0d hresp2", i), 32'(hresp2), 32'(vecs[i].e_resp));
         chk($sformatf("v%0d err_count2", i), 32'(err_count2),
             32'(vecs[i].e_count > 3 ? 3 : vecs[i].e_count));
      end

      // Test 4: saturation on the 2-bit counter, then clear+accept.
      idle_in();
      hreset = 1'b1;
      step();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 1'b1, TRANS_NONSEQ, 32'h3000 + 32'(i * 4),
               i[0], 1'b0);
         step();
         chk($sformatf("sat%0d count2", i), 32'(err_count2),
             (i + 1 > 3) ? 32'd3 : 32'(i + 1));
         chk($sformatf("sat%0d count", i), 32'(err_count), 32'(i + 1));
         chk($sformatf("sat%0d addr2", i), err_addr2, 32'h3000 + 32'(i * 4));
         drive(1'b0, 1'b1, 1'b0, TRANS_IDLE, 32'h0, 1'b0, 1'b0);
         step();
         idle_in();
         step();
         chk($sformatf("sat%0d idle", i), 32'(hresp2), 32'(OKAY));
      end
      drive(1'b0, 1'b1, 1'b1, TRANS_NONSEQ, 32'h4000, 1'b1, 1'b1);
      step();
      chk("clr_acc count2", 32'(err_count2), 32'd1);
      chk("clr_acc valid2", 32'(err_valid2), 32'd1);
      chk("clr_acc addr2", err_addr2, 32'h4000);
      chk("clr_acc count", 32'(err_count), 32'd1);
      chk("clr_acc ready", 32'(hreadyout2), 32'd0);
      idle_in();
      step();
      step();

      // Test 5: reset in the middle of a response.
      drive(1'b0, 1'b1, 1'b1, TRANS_NONSEQ, 32'h5000, 1'b0, 1'b0);
      step();
      chk("rst_mid err1", 32'(hreadyout), 32'd0);
      drive(1'b1, 1'b0, 1'b1, TRANS_IDLE, 32'h0, 1'b0, 1'b0);
      step();
      chk("rst_mid ready", 32'(hreadyout), 32'd1);
      chk("rst_mid resp", 32'(hresp), 32'(OKAY));
      chk("rst_mid count", 32'(err_count), 32'd0);
      chk("rst_mid valid", 32'(err_valid), 32'd0);
      idle_in();
      step();
      chk("rst_mid stay", 32'(hresp), 32'(OKAY));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
